// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, one full_adder step per clock, LSB first.
// Optional build macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   res_shift;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // The shared 1-bit datapath: always fed from the low bits of the shifters.
    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        // New result bit enters at the MSB so the LSB-first stream lands in place.
        res_shift            = res_sh_q >> 1;
        res_shift[WIDTH-1]   = fa_sum;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_shift;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    sum_d   = res_shift;
                    cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_carry;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// 1-bit full adder cell shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with an expected-result scoreboard queue.

module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    // {ovf, cout, sum}
    logic [9:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        int         s;
        logic [8:0] u;
        u = 9'(ta) + 9'(tb_) + 9'(tc);
        s = int'($signed(ta)) + int'($signed(tb_)) + (tc ? 1 : 0);
        return {((s > 127) || (s < -128)), u};
    endfunction

    // Drive a request at a falling edge and record its expected result.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        cin   = tc;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_, tc));
    endtask

    // Called at the first falling edge after the accept edge (sample 1).
    task automatic wait_done(output int ncyc, output int nbusy, output bit timeout);
        ncyc    = 0;
        nbusy   = 0;
        timeout = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ncyc    = i;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h exp all 0", busy, done, cout, sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", ovf);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] ta[3] = '{8'h0F, 8'hFF, 8'hFF};
        logic [7:0] tbv[3] = '{8'h01, 8'h01, 8'hFF};
        logic       tc[3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] exp;
        logic [7:0] prev_sum;
        int ncyc, nbusy;
        bit to;
        for (int k = 0; k < 3; k++) begin
            prev_sum = sum;
            issue(ta[k], tbv[k], tc[k]);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || sum !== prev_sum) begin
                failures++;
                $display("FAIL basic_run_state[%0d] got busy=%b sum=%h exp busy=1 sum=%h", k, busy, sum, prev_sum);
            end
            wait_done(ncyc, nbusy, to);
            checks++;
            if (to || ncyc != 9 || nbusy != 8) begin
                failures++;
                $display("FAIL basic_latency[%0d] got done_sample=%0d busy_cycles=%0d timeout=%0b exp 9/8/0", k, ncyc, nbusy, to);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== exp[8:0]) begin
                failures++;
                $display("FAIL basic_result[%0d] got=%h exp=%h", k, {cout, sum}, exp[8:0]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL basic_done_pulse[%0d] got done=%b busy=%b exp 0/0", k, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [9:0] exp;
        int d0, got_n;
        d0    = done_seen;
        got_n = 0;
        issue(8'h33, 8'h44, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'hBB; cin = 1'b0;
            end else if (n == 5) begin
                start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got_n = n;
                break;
            end
        end
        checks++;
        if (got_n != 9) begin
            failures++;
            $display("FAIL ignore_latency got done_sample=%0d exp=9", got_n);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== exp[8:0]) begin
            failures++;
            $display("FAIL ignore_result got=%h exp=%h", {cout, sum}, exp[8:0]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_seen - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_single_done got pulses=%0d busy=%b exp 1/0", done_seen - d0, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] exp;
        int d0, ncyc, nbusy;
        bit to;
        issue(8'h5A, 8'hA5, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_seen;
        void'(exp_q.pop_front());
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b cout=%b sum=%h exp all 0", busy, done, cout, sum);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (done_seen != d0 || sum !== 8'h00) begin
            failures++;
            $display("FAIL midrun_no_done got pulses=%0d sum=%h exp 0/00", done_seen - d0, sum);
        end
        issue(8'h21, 8'h43, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(ncyc, nbusy, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || {cout, sum} !== exp[8:0]) begin
            failures++;
            $display("FAIL midrun_recover got=%h timeout=%0b exp=%h", {cout, sum}, to, exp[8:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        int first, second, gaps;
        first  = 0;
        second = 0;
        gaps   = 0;
        issue(8'h12, 8'h34, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (first != 0 && done !== 1'b1 && busy !== 1'b1) gaps++;
            if (done === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== exp[8:0]) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] got=%h exp=%h", (first == 0) ? 0 : 1, {cout, sum}, exp[8:0]);
                end
                if (first == 0) begin
                    first = n;
                    a = 8'hA0; b = 8'h70; cin = 1'b0;
                    exp_q.push_back(model(8'hA0, 8'h70, 1'b0));
                end else begin
                    second = n;
                    start  = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (first != 9 || second - first != 9 || gaps != 0) begin
            failures++;
            $display("FAIL b2b_spacing got first=%0d spacing=%0d idle=%0d exp 9/9/0", first, second - first, gaps);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [7:0] ra, rb;
        logic       rc;
        int ncyc, nbusy;
        bit to;
        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc);
            @(negedge clk);
            start = 1'b0;
            a = ~ra;
            b = ~rb;
            wait_done(ncyc, nbusy, to);
            exp = exp_q.pop_front();
            checks++;
            if (to || ncyc != 9 || {cout, sum} !== exp[8:0]) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b got=%h sample=%0d exp=%h", k, ra, rb, rc, {cout, sum}, ncyc, exp[8:0]);
            end
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta[2] = '{8'h7F, 8'hFF};
        logic [9:0] exp;
        int ncyc, nbusy;
        bit to;
        for (int k = 0; k < 2; k++) begin
            issue(ta[k], 8'h01, 1'b0);
            @(negedge clk);
            start = 1'b0;
            wait_done(ncyc, nbusy, to);
            exp = exp_q.pop_front();
            checks++;
            if (to || {ovf, cout, sum} !== exp) begin
                failures++;
                $display("FAIL ovf[%0d] got ovf=%b cout=%b sum=%h exp=%h", k, ovf, cout, sum, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in through a single instance of the team's 1-bit full_adder cell (ports a, b, c, sum, carry), one bit per clock, LSB first.
- Sequences the operand shift registers and the carry register, and presents a start/busy/done handshake.
- Sits between a requester (CPU-style sequencer or testbench driver) and the shared full_adder datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register; holds the last completed result.
- cout  output  1  carry-out of the last completed add.

Behaviour:
- Reset: rst_n=0 asynchronously forces state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, operand and carry registers=0.
- FSM states:
  - IDLE: start=1 at edge E0 captures a, b, cin; carry_reg<=cin; cnt<=0; goes to RUN.
  - RUN: each edge applies a_sh[0], b_sh[0], carry_reg to full_adder. The FA sum bit shifts into the MSB of res_sh (right shift). carry_reg<=FA carry. a_sh and b_sh shift right. cnt++.
  - RUN exit: at the edge where cnt==WIDTH-1 (edge E_WIDTH), sum<=final res_sh value (including this bit), cout<=FA carry, state->DONE.
  - DONE: lasts exactly one cycle; done=1 and busy=0; goes to IDLE on the next edge unless start=1, in which case it goes straight to RUN with new operands (back-to-back).
- Outputs are registered: busy=1 only in RUN; done=1 only in DONE.
- Latency: done is high during the cycle following edge E_WIDTH, i.e. WIDTH cycles after the start-accept edge. Throughput is one add per WIDTH+1 cycles.
- start while busy=1 is ignored; operand inputs may change freely during RUN.
- sum and cout change only at the RUN->DONE edge. They stay stable through RUN and IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- cnt width is clog2(WIDTH), minimum 1 bit. cnt never wraps mid-operation.
- WIDTH=1: a single RUN cycle, then DONE.
- Reset asserted mid-RUN aborts the add. done is not asserted, and sum/cout return to 0.
- start held high continuously gives back-to-back adds with no IDLE cycle.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0) for signed two's-complement overflow.
  - ovf = carry into MSB XOR cout.
  - The carry into the MSB is carry_reg at the final RUN edge.
  - ovf updates and holds with sum/cout.
- Undefined: no ovf port and no extra logic.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse -> busy=1 for 8 cycles, done pulse 8 cycles after the accept edge, sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start accepted, then start re-pulsed at cycles 3 and 5 with different operands -> ignored. First result unchanged; one done pulse only.
- rst_n low at RUN cycle 4 -> busy, done, sum, cout all 0 immediately. No done pulse. A new add after release gives a correct result.
- start held high with operand pairs (8'h12,8'h34) then (8'hA0,8'h70) -> done pulses 9 cycles apart. Results 8'h46/cout 0, then 8'h10/cout 1.
- With SERIAL_ADDER_OVF_EN:
  - 8'h7F+8'h01 -> sum=8'h80, ovf=1.
  - 8'hFF+8'h01 -> ovf=0, cout=1.
